// File: rtl/bch_test_sequencer_if.sv
// ----------------------------------------------------------------------------
// bch_test_sequencer_if
// Bundles the request, encoder, decoder and result/statistics signals of the
// BCH(63,56) trial sequencer so they travel as one port.
//
//   master modport : the sequencer side (drives starts, Rn, results, counters)
//   slave modport  : the environment side (stimulus source plus enc/dec engines)
//
// Signals:
//   req_valid/req_ready, m, ne, l1..l3     request handshake and trial fields
//   enc_start, enc_msg, enc_done, enc_cw   encoder start/done handshake
//   dec_start, Rn, dec_done, dec_cw        decoder start/done handshake
//   res_valid, TorF, exp_ok, timeout       per-trial result
//   pass_cnt, fail_cnt, to_cnt, busy       statistics and status
// ----------------------------------------------------------------------------
interface bch_test_sequencer_if #(
    parameter int MSG_W = 32,
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [MSG_W-1:0] m;
    logic [1:0]       ne;
    logic [6:0]       l1;
    logic [6:0]       l2;
    logic [6:0]       l3;

    logic             enc_start;
    logic [55:0]      enc_msg;
    logic             enc_done;
    logic [62:0]      enc_cw;

    logic             dec_start;
    logic [62:0]      Rn;
    logic             dec_done;
    logic [62:0]      dec_cw;

    logic             res_valid;
    logic             TorF;
    logic             exp_ok;
    logic             timeout;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic             busy;

    modport master (
        input  req_valid, m, ne, l1, l2, l3,
        input  enc_done, enc_cw, dec_done, dec_cw,
        output req_ready, enc_start, enc_msg, dec_start, Rn,
        output res_valid, TorF, exp_ok, timeout,
        output pass_cnt, fail_cnt, to_cnt, busy
    );

    modport slave (
        output req_valid, m, ne, l1, l2, l3,
        output enc_done, enc_cw, dec_done, dec_cw,
        input  req_ready, enc_start, enc_msg, dec_start, Rn,
        input  res_valid, TorF, exp_ok, timeout,
        input  pass_cnt, fail_cnt, to_cnt, busy
    );
endinterface

// File: rtl/bch_test_sequencer.sv
// ----------------------------------------------------------------------------
// bch_test_sequencer
// Runs one BCH(63,56) encode / error-inject / decode trial per accepted
// request: starts the encoder, flips up to three codeword bits to build Rn,
// starts the decoder, compares the corrected word with the clean codeword and
// keeps saturating pass/fail/timeout statistics.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   bch_test_sequencer_if.master (request, encoder, decoder, results)
//
// Parameters:
//   MSG_W    user message width, zero-extended to the 56-bit BCH message
//   TIMEOUT  cycles allowed for enc_done / dec_done before the trial aborts
//   CNT_W    width of the saturating statistics counters
// ----------------------------------------------------------------------------
module bch_test_sequencer #(
    parameter int MSG_W   = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    bch_test_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ENC,
        INJECT,
        WAIT_DEC,
        DONE
    } state_t;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic             wait_expired;
    logic             finish;
    logic             aborted;
    logic             match;

    logic [1:0]       ne_q;
    logic [6:0]       l1_q;
    logic [6:0]       l2_q;
    logic [6:0]       l3_q;
    logic [62:0]      cw_ref;
    logic [62:0]      flip_mask;
    logic [62:0]      rn_q;
    logic [1:0]       eff_ne;
    logic [55:0]      enc_msg_q;

    logic             enc_start_q;
    logic             dec_start_q;
    logic             res_valid_q;
    logic             torf_q;
    logic             exp_ok_q;
    logic             timeout_q;
    logic             busy_q;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic [CNT_W-1:0] to_q;

    // The wait counter holds the number of cycles already spent in the current
    // wait state, so the trial aborts on the TIMEOUT-th cycle without a done.
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // A trial finishes whenever the FSM is about to enter DONE; it counts as a
    // normal completion only when the decoder answered in WAIT_DEC.
    assign finish  = (next_state == DONE);
    assign aborted = !((state == WAIT_DEC) && bus.dec_done);
    assign match   = (bus.dec_cw == cw_ref);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A done pulse beats a timeout in the same cycle, and
    // done pulses seen in states that are not waiting for them are ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (bus.req_valid) next_state = WAIT_ENC;
            WAIT_ENC: begin
                if (bus.enc_done)      next_state = INJECT;
                else if (wait_expired) next_state = DONE;
            end
            INJECT:   next_state = WAIT_DEC;
            WAIT_DEC: begin
                if (bus.dec_done)      next_state = DONE;
                else if (wait_expired) next_state = DONE;
            end
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Error mask built from the latched request. Each active location flips
    // one bit counted from the MSB side; locations past 62 fall off the word,
    // and repeated locations toggle the same bit back, cancelling out.
    always_comb begin
        flip_mask = '0;
        if (ne_q >= 2'd1 && l1_q <= 7'd62) flip_mask = flip_mask ^ (63'd1 << (7'd62 - l1_q));
        if (ne_q >= 2'd2 && l2_q <= 7'd62) flip_mask = flip_mask ^ (63'd1 << (7'd62 - l2_q));
        if (ne_q >= 2'd3 && l3_q <= 7'd62) flip_mask = flip_mask ^ (63'd1 << (7'd62 - l3_q));
    end

    // Datapath and registered outputs. Start and result pulses default low
    // every cycle; the result fields and counters update on the edge that
    // enters DONE so they are already valid while res_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            ne_q        <= '0;
            l1_q        <= '0;
            l2_q        <= '0;
            l3_q        <= '0;
            cw_ref      <= '0;
            rn_q        <= '0;
            eff_ne      <= '0;
            enc_msg_q   <= '0;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            torf_q      <= 1'b0;
            exp_ok_q    <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            to_q        <= '0;
        end else begin
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= (next_state != IDLE);

            if ((next_state == state) && (state == WAIT_ENC || state == WAIT_DEC)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ne_q        <= bus.ne;
                        l1_q        <= bus.l1;
                        l2_q        <= bus.l2;
                        l3_q        <= bus.l3;
                        enc_msg_q   <= 56'(bus.m);
                        enc_start_q <= 1'b1;
                    end
                end
                WAIT_ENC: begin
                    if (bus.enc_done) cw_ref <= bus.enc_cw;
                end
                INJECT: begin
                    rn_q        <= cw_ref ^ flip_mask;
                    eff_ne      <= 2'($countones(flip_mask));
                    dec_start_q <= 1'b1;
                end
                default: begin
                end
            endcase

            if (finish) begin
                res_valid_q <= 1'b1;
                timeout_q   <= aborted;
                if (aborted) begin
                    torf_q   <= 1'b0;
                    exp_ok_q <= 1'b0;
                    if (to_q != '1) to_q <= to_q + CNT_W'(1);
                end else begin
                    torf_q   <= match;
                    exp_ok_q <= (match == (eff_ne <= 2'd1));
                    if (match) begin
                        if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
                    end else begin
                        if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.enc_start = enc_start_q;
    assign bus.enc_msg   = enc_msg_q;
    assign bus.dec_start = dec_start_q;
    assign bus.Rn        = rn_q;
    assign bus.res_valid = res_valid_q;
    assign bus.TorF      = torf_q;
    assign bus.exp_ok    = exp_ok_q;
    assign bus.timeout   = timeout_q;
    assign bus.pass_cnt  = pass_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.to_cnt    = to_q;
    assign bus.busy      = busy_q;

endmodule
